// File: rtl/keycode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keycode_pkg
// Description : Shared constants and types for the keycode report PIO:
//               register map, STATUS bit positions, diff-engine FSM states
//               and the event record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package keycode_pkg;

  // Register map (word addresses on the Avalon-MM slave)
  localparam logic [3:0] ADDR_SLOT0   = 4'd0;
  localparam logic [3:0] ADDR_COMMIT  = 4'd8;
  localparam logic [3:0] ADDR_STATUS  = 4'd9;
  localparam logic [3:0] ADDR_ACTIVE0 = 4'd10;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_PEND    = 2;
  localparam int STAT_IRQM    = 3;
  localparam int STAT_CNT_LSB = 8;

  // Diff-engine states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN_REL = 2'd1,
    ST_SCAN_PRS = 2'd2,
    ST_DONE     = 2'd3
  } kc_state_t;

  // Event record for the default 8-bit keycode width: {press, code}
  localparam int EVT_KEY_W = 8;
  typedef struct packed {
    logic                 press;
    logic [EVT_KEY_W-1:0] code;
  } keycode_event_t;

endpackage
`default_nettype wire

// File: rtl/keycode_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keycode_evt_fifo
// Description : Synchronous show-ahead FIFO with occupancy count. A push
//               into a full FIFO is dropped (flagged on 'dropped') unless a
//               pop happens in the same cycle, in which case it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_evt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int C_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign full      = (r_count == (C_AW+1)'(DEPTH));
  assign valid     = (r_count != '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && valid;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dropped   = push && !w_push_ok;

  // Storage array: written on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^n)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keycode_report_pio.sv
`default_nettype none
// ============================================================================
// Module      : keycode_report_pio
// Description : Avalon-MM slave that stages a HID keyboard report, commits it
//               atomically to keys_out and diffs it against the previous
//               report, emitting release/press events into a FIFO.
//               Optional: define KEYCODE_IRQ_EN to add the irq output and the
//               STATUS irq_mask bit.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_report_pio
  import keycode_pkg::*;
#(
  parameter int NUM_KEYS   = 6,
  parameter int KEY_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_KEYS*KEY_W-1:0] keys_out,
  output logic [KEY_W:0]            ev_data,
  output logic                      ev_valid,
  input  logic                      ev_ready
`ifdef KEYCODE_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int C_IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int C_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_KEYS-1:0][KEY_W-1:0] r_staging;
  logic [NUM_KEYS-1:0][KEY_W-1:0] r_active;
  logic [NUM_KEYS-1:0][KEY_W-1:0] r_prev;
  kc_state_t                      r_state;
  kc_state_t                      w_state_nxt;
  logic [C_IDX_W-1:0]             r_idx;
  logic                           r_pending;
  logic                           r_overflow;
  logic                           w_wr_en;
  logic                           w_commit_wr;
  logic                           w_status_wr;
  logic                           w_busy;
  logic                           w_do_commit;
  logic                           w_last;
  logic [KEY_W-1:0]               w_sel_prev;
  logic [KEY_W-1:0]               w_sel_act;
  logic                           w_prev_in_act;
  logic                           w_act_in_prev;
  logic                           w_push;
  logic [KEY_W:0]                 w_push_data;
  logic                           w_dropped;
  logic                           w_full;
  logic [C_CNT_W-1:0]             w_count;
  logic                           w_irq_mask;
  logic [31:0]                    w_status;
  logic                           w_unused;

  assign w_wr_en     = chipselect && !write_n;
  assign w_commit_wr = w_wr_en && (address == ADDR_COMMIT);
  assign w_status_wr = w_wr_en && (address == ADDR_STATUS);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_last      = (r_idx == C_IDX_W'(NUM_KEYS - 1));
  // A commit arriving during DONE is folded into the pending restart
  assign w_do_commit = ((r_state == ST_IDLE) && w_commit_wr) ||
                       ((r_state == ST_DONE) && (r_pending || w_commit_wr));
  assign keys_out    = r_active;
  assign w_unused    = &{1'b0, writedata, w_full};

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state: scan releases, then presses, then settle in DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_do_commit) w_state_nxt = ST_SCAN_REL;
      ST_SCAN_REL: if (w_last)      w_state_nxt = ST_SCAN_PRS;
      ST_SCAN_PRS: if (w_last)      w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = w_do_commit ? ST_SCAN_REL : ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Report registers, scan index, pending and overflow flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_staging  <= '0;
      r_active   <= '0;
      r_prev     <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_wr_en && (address == ADDR_SLOT0 + 4'(i))) r_staging[i] <= writedata[KEY_W-1:0];
      end
      if (w_do_commit) begin
        r_prev   <= r_active;
        r_active <= r_staging;
        r_idx    <= '0;
      end else if ((r_state == ST_SCAN_REL) || (r_state == ST_SCAN_PRS)) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_do_commit)                   r_pending <= 1'b0;
      else if (w_commit_wr && w_busy)    r_pending <= 1'b1;
      // A drop in the same cycle as a clear wins
      if (w_dropped)                                 r_overflow <= 1'b1;
      else if (w_status_wr && writedata[STAT_OVF])   r_overflow <= 1'b0;
    end
  end

  // Diff engine: select slot r_idx and compare it against every slot of the other report
  always_comb begin
    w_sel_prev    = '0;
    w_sel_act     = '0;
    w_prev_in_act = 1'b0;
    w_act_in_prev = 1'b0;
    w_push        = 1'b0;
    w_push_data   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (r_idx == C_IDX_W'(i)) begin
        w_sel_prev = r_prev[i];
        w_sel_act  = r_active[i];
      end
    end
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (r_active[j] == w_sel_prev) w_prev_in_act = 1'b1;
      if (r_prev[j]   == w_sel_act)  w_act_in_prev = 1'b1;
    end
    if ((r_state == ST_SCAN_REL) && (w_sel_prev != '0) && !w_prev_in_act) begin
      w_push      = 1'b1;
      w_push_data = {1'b0, w_sel_prev};
    end else if ((r_state == ST_SCAN_PRS) && (w_sel_act != '0) && !w_act_in_prev) begin
      w_push      = 1'b1;
      w_push_data = {1'b1, w_sel_act};
    end
  end

  keycode_evt_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (ev_ready),
    .head      (ev_data),
    .valid     (ev_valid),
    .full      (w_full),
    .count     (w_count),
    .dropped   (w_dropped)
  );

`ifdef KEYCODE_IRQ_EN
  logic r_irq_mask;

  // Interrupt mask register and registered interrupt output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (w_status_wr) r_irq_mask <= writedata[STAT_IRQM];
      irq <= r_irq_mask && (ev_valid || r_overflow);
    end
  end

  assign w_irq_mask = r_irq_mask;
`else
  assign w_irq_mask = 1'b0;
`endif

  // STATUS word assembly and zero-wait-state read mux
  always_comb begin
    w_status                        = '0;
    w_status[STAT_BUSY]             = w_busy;
    w_status[STAT_OVF]              = r_overflow;
    w_status[STAT_PEND]             = r_pending;
    w_status[STAT_IRQM]             = w_irq_mask;
    w_status[STAT_CNT_LSB +: 8]     = 8'(w_count);
    readdata = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (address == ADDR_SLOT0 + 4'(i)) readdata = 32'(r_staging[i]);
    end
    if (address == ADDR_STATUS)  readdata = w_status;
    if (address == ADDR_ACTIVE0) readdata = 32'(r_active[0]);
  end

endmodule
`default_nettype wire

// File: tb/tb_keycode_report_pio.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_report_pio
// Description : Self-checking bench for keycode_report_pio. Instance 0 uses
//               the default configuration; instance 1 uses a 2-entry FIFO
//               for overflow scenarios. Expected events are queued when a
//               commit is issued and compared as the consumer pops them.
//               Define KEYCODE_IRQ_EN to include the interrupt scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_report_pio;

  localparam int NK = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address    [2];
  logic        chipselect [2];
  logic        write_n    [2];
  logic [31:0] writedata  [2];
  logic [31:0] readdata   [2];
  logic [47:0] keys_out   [2];
  logic [8:0]  ev_data    [2];
  logic        ev_valid   [2];
  logic        ev_ready   [2];
`ifdef KEYCODE_IRQ_EN
  logic        irq        [2];
`endif

  int          n_vec = 0;
  int          n_mis = 0;
  logic [8:0]  sb [$];

  always #5 clk = ~clk;

  keycode_report_pio #(.NUM_KEYS(NK), .KEY_W(8), .FIFO_DEPTH(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
    .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]),
    .keys_out(keys_out[0]), .ev_data(ev_data[0]), .ev_valid(ev_valid[0]),
    .ev_ready(ev_ready[0])
`ifdef KEYCODE_IRQ_EN
    , .irq(irq[0])
`endif
  );

  keycode_report_pio #(.NUM_KEYS(NK), .KEY_W(8), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
    .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]),
    .keys_out(keys_out[1]), .ev_data(ev_data[1]), .ev_valid(ev_valid[1]),
    .ev_ready(ev_ready[1])
`ifdef KEYCODE_IRQ_EN
    , .irq(irq[1])
`endif
  );

  // Single-cycle bus write; entered and left 1 ns after a rising edge
  task automatic wr(input int u, input logic [3:0] a, input logic [31:0] d);
    address[u] = a; writedata[u] = d; chipselect[u] = 1'b1; write_n[u] = 1'b0;
    @(posedge clk); #1;
    chipselect[u] = 1'b0; write_n[u] = 1'b1;
  endtask

  // Combinational read, no clock edge consumed
  task automatic rd(input int u, input logic [3:0] a, output logic [31:0] d);
    address[u] = a; #1; d = readdata[u];
  endtask

  task automatic wait_idle(input int u, input int budget, output int cycles);
    logic [31:0] s;
    cycles = 0;
    rd(u, 4'd9, s);
    while (s[0] && cycles < budget) begin
      @(posedge clk); #1; cycles++; rd(u, 4'd9, s);
    end
    n_vec++;
    if (s[0]) begin n_mis++; $display("FAIL idle_timeout: busy still %0d after %0d cycles, required 0", s[0], cycles); end
  endtask

  // Pop every event and compare it against the scoreboard head
  task automatic drain(input int u, input int budget);
    logic [8:0] e;
    ev_ready[u] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (ev_valid[u]) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_mis++; $display("FAIL unexpected_event: got %h, required no event", ev_data[u]);
        end else begin
          e = sb.pop_front();
          if (ev_data[u] !== e) begin n_mis++; $display("FAIL event: got %h, required %h", ev_data[u], e); end
        end
      end else if (sb.size() == 0) begin
        break;
      end
      @(posedge clk); #1;
    end
    ev_ready[u] = 1'b0;
    n_vec++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL missing_events: %0d still queued, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      n_vec++; if (keys_out[u] !== 48'h0) begin n_mis++; $display("FAIL reset_keys: got %h, required 0", keys_out[u]); end
      n_vec++; if (ev_valid[u] !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b, required 0", ev_valid[u]); end
      rd(u, 4'd9, s);
      n_vec++; if (s !== 32'h0) begin n_mis++; $display("FAIL reset_status: got %h, required 0", s); end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_press();
    int k;
    wr(0, 4'd0, 32'h04);
    sb.push_back({1'b1, 8'h04});
    wr(0, 4'd8, 32'h0);
    n_vec++; if (keys_out[0] !== 48'h04) begin n_mis++; $display("FAIL single_keys: got %h, required %h", keys_out[0], 48'h04); end
    wait_idle(0, 100, k);
    n_vec++; if (k != 2*NK+1) begin n_mis++; $display("FAIL busy_len: got %0d, required %0d", k, 2*NK+1); end
    drain(0, 20);
  endtask

  task automatic test_report_change();
    int k;
    wr(0, 4'd1, 32'h16);
    sb.push_back({1'b1, 8'h16});
    wr(0, 4'd8, 32'h0);
    wait_idle(0, 100, k);
    drain(0, 20);
    wr(0, 4'd0, 32'h16);
    wr(0, 4'd1, 32'h1A);
    sb.push_back({1'b0, 8'h04});
    sb.push_back({1'b1, 8'h1A});
    wr(0, 4'd8, 32'h0);
    n_vec++; if (keys_out[0] !== 48'h1A16) begin n_mis++; $display("FAIL change_keys: got %h, required %h", keys_out[0], 48'h1A16); end
    wait_idle(0, 100, k);
    drain(0, 20);
  endtask

  task automatic test_commit_busy();
    logic [31:0] s;
    int k;
    wr(0, 4'd0, 32'h04);
    wr(0, 4'd1, 32'h00);
    sb.push_back({1'b0, 8'h16});
    sb.push_back({1'b0, 8'h1A});
    sb.push_back({1'b1, 8'h04});
    sb.push_back({1'b0, 8'h04});
    sb.push_back({1'b1, 8'h05});
    wr(0, 4'd8, 32'h0);
    wr(0, 4'd0, 32'h05);
    wr(0, 4'd8, 32'h0);
    rd(0, 4'd9, s);
    n_vec++; if (s[2:0] !== 3'b101) begin n_mis++; $display("FAIL pending: got %b, required 101", s[2:0]); end
    wait_idle(0, 200, k);
    drain(0, 30);
    n_vec++; if (keys_out[0] !== 48'h05) begin n_mis++; $display("FAIL busy_keys: got %h, required %h", keys_out[0], 48'h05); end
    rd(0, 4'd10, s);
    n_vec++; if (s !== 32'h05) begin n_mis++; $display("FAIL active0: got %h, required 05", s); end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    int k;
    for (int i = 0; i < NK; i++) wr(1, 4'(i), 32'h10 + i);
    wr(1, 4'd8, 32'h0);
    wait_idle(1, 100, k);
    rd(1, 4'd9, s);
    n_vec++; if (s !== 32'h0202) begin n_mis++; $display("FAIL ovf_status: got %h, required 0202", s); end
    sb.push_back({1'b1, 8'h10});
    sb.push_back({1'b1, 8'h11});
    drain(1, 20);
    rd(1, 4'd9, s);
    n_vec++; if (s !== 32'h0002) begin n_mis++; $display("FAIL ovf_sticky: got %h, required 0002", s); end
    wr(1, 4'd9, 32'h2);
    rd(1, 4'd9, s);
    n_vec++; if (s !== 32'h0) begin n_mis++; $display("FAIL ovf_clear: got %h, required 0", s); end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] s;
    wr(0, 4'd0, 32'h30);
    wr(0, 4'd8, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++; if (ev_valid[0] !== 1'b1) begin n_mis++; $display("FAIL midscan_valid: got %b, required 1", ev_valid[0]); end
    reset_n = 1'b0;
    #2;
    n_vec++; if (keys_out[0] !== 48'h0) begin n_mis++; $display("FAIL midscan_keys: got %h, required 0", keys_out[0]); end
    n_vec++; if (ev_valid[0] !== 1'b0) begin n_mis++; $display("FAIL midscan_fifo: got %b, required 0", ev_valid[0]); end
    rd(0, 4'd0, s);
    n_vec++; if (s !== 32'h0) begin n_mis++; $display("FAIL midscan_slot: got %h, required 0", s); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(0, 4'd9, s);
    n_vec++; if (s !== 32'h0) begin n_mis++; $display("FAIL midscan_status: got %h, required 0", s); end
  endtask

`ifdef KEYCODE_IRQ_EN
  task automatic test_irq();
    logic [31:0] s;
    int k;
    wr(0, 4'd9, 32'h8);
    rd(0, 4'd9, s);
    n_vec++; if (s !== 32'h8) begin n_mis++; $display("FAIL irq_mask: got %h, required 8", s); end
    wr(0, 4'd0, 32'h22);
    sb.push_back({1'b1, 8'h22});
    wr(0, 4'd8, 32'h0);
    k = 0;
    while (!ev_valid[0] && k < 50) begin @(posedge clk); #1; k++; end
    n_vec++; if (ev_valid[0] !== 1'b1) begin n_mis++; $display("FAIL irq_wait: valid %b, required 1", ev_valid[0]); end
    n_vec++; if (irq[0] !== 1'b0) begin n_mis++; $display("FAIL irq_early: got %b, required 0", irq[0]); end
    @(posedge clk); #1;
    n_vec++; if (irq[0] !== 1'b1) begin n_mis++; $display("FAIL irq_set: got %b, required 1", irq[0]); end
    wait_idle(0, 100, k);
    drain(0, 20);
    @(posedge clk); #1;
    n_vec++; if (irq[0] !== 1'b0) begin n_mis++; $display("FAIL irq_clear: got %b, required 0", irq[0]); end
  endtask
`endif

  initial begin
    for (int u = 0; u < 2; u++) begin
      address[u] = '0; chipselect[u] = 1'b0; write_n[u] = 1'b1;
      writedata[u] = '0; ev_ready[u] = 1'b0;
    end
    test_reset();
    test_single_press();
    test_report_change();
    test_commit_busy();
    test_overflow();
    test_reset_mid_scan();
`ifdef KEYCODE_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keycode_report_pio.md
Name: keycode_report_pio

Overview:
Avalon-MM slave through which the NIOS writes a full USB HID keyboard report, up to NUM_KEYS simultaneous keycodes, into staging slots and then commits it atomically.
- The committed report drives `keys_out` for the game logic.
- A sequential diff engine compares the new report with the previous one and pushes press/release events into an event FIFO.
- Hardware consumers pop events through a valid/ready port.

Parameters:
- NUM_KEYS, 6, keycode slots per report; 1..8.
- KEY_W, 8, keycode width; code 0 means "no key".
- FIFO_DEPTH, 16, event FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  4  register select
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write, active low
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (zero wait states)
- keys_out  out  NUM_KEYS*KEY_W  committed report; slot i at bits [i*KEY_W +: KEY_W]
- ev_data  out  KEY_W+1  FIFO head; bit KEY_W = 1 for press, 0 for release; low bits = keycode
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer pop

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset state: all slots, active and previous regs = 0; keys_out = 0; FIFO empty; ev_valid = 0; overflow = 0; pending = 0; FSM in IDLE.
- Write strobe: chipselect && !write_n.
- Address map:
  - 0..7: staging slot. Write loads writedata[KEY_W-1:0]. Read returns the staging value. Slots >= NUM_KEYS read 0 and ignore writes.
  - 8: COMMIT. Any write triggers a commit.
  - 9: STATUS. Read: bit0 busy, bit1 overflow, bit2 pending, bits[15:8] FIFO count. Write 1 to bit1 clears overflow.
  - 10: ACTIVE slot 0 readback.
  - Others: read 0, writes ignored.
- Commit in IDLE: in the same edge, prev <= active and active <= staging. keys_out updates on the next cycle. The FSM goes to SCAN_REL with index 0.
- Commit while busy: sets pending (one level only; further commits merge). When DONE is reached with pending set: perform the commit and clear pending. Staging holds its latest value.
- FSM: IDLE -> SCAN_REL -> SCAN_PRS -> DONE -> IDLE.
  - SCAN_REL: one slot per cycle. If prev[i] != 0 and prev[i] matches no active[j] (parallel compare), push {0, prev[i]}.
  - SCAN_PRS: one slot per cycle. If active[i] != 0 and active[i] matches no prev[j], push {1, active[i]}.
  - Latency from commit write to the last possible push: 2*NUM_KEYS cycles. busy is high in every state except IDLE.
- Duplicate nonzero keys within a report are processed per slot, so each duplicate slot yields its own event.
- FIFO: show-ahead.
  - Pop when ev_valid && ev_ready.
  - A push while full is dropped, sets overflow sticky, and does not stall the scan.
  - Simultaneous push and pop when full: the push is accepted and count is unchanged.
  - Simultaneous push and pop when empty: the push is stored and ev_valid asserts next cycle.
- Overflow: a clear and a set in the same cycle leave overflow set.
- Reset mid-scan: the scan is abandoned and everything returns to reset state.

Optional Feature:
- KEYCODE_IRQ_EN defined:
  - Adds output irq (1 bit, reset 0) and STATUS bit3 irq_mask (read/write, reset 0).
  - irq is registered: irq = irq_mask && (ev_valid || overflow).
- Not defined: no irq port; STATUS bit3 reads 0 and is not writable.

Decomposition:
- Package keycode_pkg:
  - register address constants (ADDR_SLOT0, ADDR_COMMIT, ADDR_STATUS, ADDR_ACTIVE0);
  - STATUS bit indices;
  - FSM state enum;
  - keycode_event_t as {press, code}.
- Sub-module keycode_evt_fifo: generic synchronous show-ahead FIFO with count, full/empty and drop-on-full handling.

Test Plan:
- Reset: after reset, keys_out = 0, ev_valid = 0, STATUS reads 0x0.
- Single press: slot0 = 0x04, others 0, commit -> keys_out slot0 = 0x04; exactly one event {1,0x04}; busy drops after 2*NUM_KEYS+1 cycles.
- Report change: active {0x04,0x16}, then commit {0x16,0x1A} -> events in order {0,0x04}, then {1,0x1A}; no event for 0x16.
- Overflow: FIFO_DEPTH=2, ev_ready=0, commit 6 new keys -> 2 events kept (the first two press events, slots 0 and 1), STATUS bit1 = 1, count = 2. Write 0x2 to STATUS -> bit1 = 0.
- Commit while busy: two back-to-back commits ({0x04}, then {0x05}) -> pending = 1; after the first scan the second commit runs; events in order {1,0x04}, {0,0x04}, {1,0x05}.
- KEYCODE_IRQ_EN: set irq_mask, commit one key -> irq = 1 one cycle after ev_valid; pop the event -> irq = 0.
